// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one synchronous FIFO write port among
//   NUM_REQ valid/ready producers. A producer owns the port for a burst of
//   up to MAX_BURST words. It then gives up the port for one idle cycle
//   while the next owner is picked.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester data valid
//   req_data    requester i word at [i*WIDTH +: WIDTH]
//   req_ready   per-requester accept (at most one bit set)
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write enable
//   fifo_wdata  FIFO write data (zero while idle)
//   grant_id    current owner index
//   busy        high while a grant is active
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] last_owner, last_owner_nxt;
  logic [CW-1:0]  burst_cnt, burst_cnt_nxt;

  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] scan_id;
  logic           scan_hit;
  logic           owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic           xfer;

  // Round-robin search starting just after the previous owner, wrapping
  // at NUM_REQ (which need not be a power of two).
  always_comb begin
    scan_hit = 1'b0;
    scan_id  = '0;
    scan_idx = (last_owner == LAST_ID) ? '0 : last_owner + IDW'(1);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!scan_hit && req_valid[scan_idx]) begin
        scan_hit = 1'b1;
        scan_id  = scan_idx;
      end
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + IDW'(1);
    end
  end

  // Owner's valid and data slice.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IDW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = (state == GRANT) && owner_valid && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_ID;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    req_ready      = '0;
    fifo_wr_en     = 1'b0;
    fifo_wdata     = '0;
    busy           = 1'b0;

    unique case (state)
      IDLE: begin
        if (scan_hit) begin
          owner_nxt     = scan_id;
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end

      GRANT: begin
        busy       = 1'b1;
        fifo_wr_en = xfer;
        fifo_wdata = owner_data;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (owner == IDW'(i)) && !fifo_full;
        end
        // A dropped valid releases even while the FIFO is full; otherwise
        // a stalled grant is held with its count intact.
        if (!owner_valid) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
        end else if (xfer) begin
          if (burst_cnt == LAST_BEAT) begin
            state_nxt      = IDLE;
            last_owner_nxt = owner;
          end else begin
            burst_cnt_nxt = burst_cnt + CW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign grant_id = owner;

endmodule
